// File: rtl/md_bus_resolver.sv
// Registered resolver for a shared multi-driver board bus with idle keeper/pull handling
// and a contention monitor (per-cycle, sticky, saturating count, first-conflict capture).
module md_bus_resolver #(
  parameter int              WIDTH     = 16,
  parameter int              NDRV      = 4,
  parameter int              IDLE_MODE = 0,
  parameter int              RESOLVE   = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter int              CNT_W     = 8
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic [NDRV*WIDTH-1:0] drv_o,
  input  logic [NDRV*WIDTH-1:0] drv_d,
  input  logic                  clr,
  output logic [WIDTH-1:0]      bus,
  output logic [WIDTH-1:0]      bus_driven,
  output logic                  contention,
  output logic                  contention_sticky,
  output logic [CNT_W-1:0]      contention_count,
  output logic [NDRV-1:0]       first_mask,
  output logic [WIDTH-1:0]      first_bits
);

  if ((NDRV < 2) || (WIDTH < 1) || (CNT_W < 1) || (IDLE_MODE > 2)) begin : g_param_err
    $error("md_bus_resolver: illegal parameters NDRV=%0d WIDTH=%0d CNT_W=%0d IDLE_MODE=%0d",
           NDRV, WIDTH, CNT_W, IDLE_MODE);
  end

  logic [WIDTH-1:0] any_one;
  logic [WIDTH-1:0] any_zero;
  logic [WIDTH-1:0] driven;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] idle_val;
  logic [WIDTH-1:0] bus_next;
  logic [WIDTH-1:0] conflict_bits;
  logic [NDRV-1:0]  conflict_mask;
  logic             cycle_conflict;

  // A bit conflicts exactly when its active drivers include both a 1 and a 0.
  always_comb begin
    any_one       = '0;
    any_zero      = '0;
    conflict_mask = '0;
    for (int k = 0; k < NDRV; k++) begin
      any_one  = any_one  | ( drv_o[k*WIDTH +: WIDTH] & ~drv_d[k*WIDTH +: WIDTH]);
      any_zero = any_zero | (~drv_o[k*WIDTH +: WIDTH] & ~drv_d[k*WIDTH +: WIDTH]);
    end
    driven         = any_one | any_zero;
    conflict_bits  = any_one & any_zero;
    cycle_conflict = |conflict_bits;
    for (int k = 0; k < NDRV; k++) begin
      conflict_mask[k] = |(conflict_bits & ~drv_d[k*WIDTH +: WIDTH]);
    end
    merged = (RESOLVE == 1) ? ~any_zero : any_one;
    if (IDLE_MODE == 1)      idle_val = '1;
    else if (IDLE_MODE == 2) idle_val = '0;
    else                     idle_val = bus;
    bus_next = (merged & driven) | (idle_val & ~driven);
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      bus        <= RESET_VAL;
      bus_driven <= '0;
      contention <= 1'b0;
    end else begin
      bus        <= bus_next;
      bus_driven <= driven;
      contention <= cycle_conflict;
    end
  end

  // A clear coinciding with a conflict restarts the record from this conflict.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      contention_sticky <= 1'b0;
      contention_count  <= '0;
      first_mask        <= '0;
      first_bits        <= '0;
    end else if (cycle_conflict) begin
      contention_sticky <= 1'b1;
      if (clr) begin
        contention_count <= CNT_W'(1);
      end else if (contention_count != {CNT_W{1'b1}}) begin
        contention_count <= contention_count + 1'b1;
      end
      if (clr || !contention_sticky) begin
        first_mask <= conflict_mask;
        first_bits <= conflict_bits;
      end
    end else if (clr) begin
      contention_sticky <= 1'b0;
      contention_count  <= '0;
      first_mask        <= '0;
      first_bits        <= '0;
    end
  end

endmodule

// File: tb/tb_md_bus_resolver.sv
// Bench for md_bus_resolver: five parameter variants share one stimulus stream and are
// compared every cycle against a per-bit counting model, plus directed literal checks.
module tb_md_bus_resolver;

  localparam int W  = 16;
  localparam int ND = 4;
  localparam int NC = 5;

  logic           MCLK;
  logic           reset;
  logic [ND*W-1:0] drv_o;
  logic [ND*W-1:0] drv_d;
  logic           clr;

  logic [W-1:0]  o_bus    [NC];
  logic [W-1:0]  o_drv    [NC];
  logic          o_cont   [NC];
  logic          o_sticky [NC];
  logic [7:0]    o_cnt    [NC];
  logic [ND-1:0] o_fmask  [NC];
  logic [W-1:0]  o_fbits  [NC];

  // variant c: 0 keeper/OR, 1 pull-up/OR, 2 pull-down/OR, 3 keeper/OR/CNT_W=3, 4 pull-up/AND
  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int IM = (g == 1 || g == 4) ? 1 : ((g == 2) ? 2 : 0);
    localparam int RS = (g == 4) ? 1 : 0;
    localparam int CW = (g == 3) ? 3 : 8;
    logic [W-1:0]  bus_w, drv_w, fbits_w;
    logic          cont_w, sticky_w;
    logic [CW-1:0] cnt_w;
    logic [ND-1:0] fmask_w;
    md_bus_resolver #(.WIDTH(W), .NDRV(ND), .IDLE_MODE(IM), .RESOLVE(RS),
                      .RESET_VAL({W{1'b1}}), .CNT_W(CW)) dut (
      .MCLK(MCLK), .reset(reset), .drv_o(drv_o), .drv_d(drv_d), .clr(clr),
      .bus(bus_w), .bus_driven(drv_w), .contention(cont_w),
      .contention_sticky(sticky_w), .contention_count(cnt_w),
      .first_mask(fmask_w), .first_bits(fbits_w));
    assign o_bus[g]    = bus_w;
    assign o_drv[g]    = drv_w;
    assign o_cont[g]   = cont_w;
    assign o_sticky[g] = sticky_w;
    assign o_cnt[g]    = 8'(cnt_w);
    assign o_fmask[g]  = fmask_w;
    assign o_fbits[g]  = fbits_w;
  end

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int n_pass = 0;
  int n_tot  = 0;

  logic [W-1:0]  m_bus [NC], m_drv [NC], m_fbits [NC];
  logic          m_cont [NC], m_sticky [NC];
  int            m_cnt [NC];
  logic [ND-1:0] m_fmask [NC];

  function automatic int idle_of(int c); return (c == 1 || c == 4) ? 1 : ((c == 2) ? 2 : 0); endfunction
  function automatic int and_of(int c);  return (c == 4) ? 1 : 0; endfunction
  function automatic int cmax_of(int c); return (c == 3) ? 7 : 255; endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_bus[c] = '1; m_drv[c] = '0; m_fbits[c] = '0; m_fmask[c] = '0;
      m_cont[c] = 1'b0; m_sticky[c] = 1'b0; m_cnt[c] = 0;
    end
  endtask

  // Count active drivers and how many of them drive a 1, bit by bit.
  task automatic model_edge();
    int            n_act, n_one;
    logic [W-1:0]  cbits, dbits, val;
    logic [ND-1:0] cmask;
    bit            cyc;
    cbits = '0; dbits = '0; cmask = '0;
    for (int c = 0; c < NC; c++) begin
      for (int b = 0; b < W; b++) begin
        n_act = 0; n_one = 0;
        for (int k = 0; k < ND; k++) begin
          if (drv_d[k*W+b] == 1'b0) begin
            n_act++;
            n_one += int'(drv_o[k*W+b]);
          end
        end
        cbits[b] = (n_one != 0) && (n_one != n_act);
        dbits[b] = (n_act != 0);
        if (n_act == 0) begin
          if (idle_of(c) == 1)      val[b] = 1'b1;
          else if (idle_of(c) == 2) val[b] = 1'b0;
          else                      val[b] = m_bus[c][b];
        end else if (and_of(c) == 1) val[b] = (n_one == n_act);
        else                         val[b] = (n_one > 0);
        if (cbits[b]) begin
          for (int k = 0; k < ND; k++) if (drv_d[k*W+b] == 1'b0) cmask[k] = 1'b1;
        end
      end
      cyc = (cbits != 0);
      m_bus[c]  = val;
      m_drv[c]  = dbits;
      m_cont[c] = cyc;
      if (cyc) begin
        if (clr || !m_sticky[c]) begin
          m_fmask[c] = cmask;
          m_fbits[c] = cbits;
        end
        m_cnt[c]    = clr ? 1 : ((m_cnt[c] < cmax_of(c)) ? m_cnt[c] + 1 : m_cnt[c]);
        m_sticky[c] = 1'b1;
      end else if (clr) begin
        m_cnt[c] = 0; m_sticky[c] = 1'b0; m_fmask[c] = '0; m_fbits[c] = '0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("dut%0d bus", c),        32'(o_bus[c]),    32'(m_bus[c]));
      chk($sformatf("dut%0d bus_driven", c), 32'(o_drv[c]),    32'(m_drv[c]));
      chk($sformatf("dut%0d contention", c), 32'(o_cont[c]),   32'(m_cont[c]));
      chk($sformatf("dut%0d sticky", c),     32'(o_sticky[c]), 32'(m_sticky[c]));
      chk($sformatf("dut%0d count", c),      32'(o_cnt[c]),    32'(m_cnt[c]));
      chk($sformatf("dut%0d first_mask", c), 32'(o_fmask[c]),  32'(m_fmask[c]));
      chk($sformatf("dut%0d first_bits", c), 32'(o_fbits[c]),  32'(m_fbits[c]));
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    if (reset) model_reset(); else model_edge();
    @(negedge MCLK);
    check_all();
  endtask

  task automatic set_drv(input int k, input logic [W-1:0] v, input logic [W-1:0] d);
    drv_o[k*W +: W] = v;
    drv_d[k*W +: W] = d;
  endtask

  task automatic release_all();
    drv_o = '0;
    drv_d = '1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] shared;
    int r;
    reset = 1'b1; clr = 1'b0;
    release_all();
    model_reset();
    step(); step();
    chk("reset bus", 32'(o_bus[0]), 32'hFFFF);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("idle keep bus", 32'(o_bus[0]), 32'hFFFF);
    chk("idle driven",   32'(o_drv[0]), 32'h0000);
    chk("idle sticky",   32'(o_sticky[0]), 32'h0);

    set_drv(1, 16'h1234, 16'h0000);
    step();
    chk("drive bus", 32'(o_bus[0]), 32'h1234);
    release_all();
    step();
    chk("pullup bus",   32'(o_bus[1]), 32'hFFFF);
    chk("pulldown bus", 32'(o_bus[2]), 32'h0000);
    for (int i = 0; i < 9; i++) step();
    chk("keeper hold bus", 32'(o_bus[0]), 32'h1234);

    set_drv(0, 16'h005A, 16'hFF00);
    step();
    chk("partial bus",    32'(o_bus[0]), 32'h125A);
    chk("partial driven", 32'(o_drv[0]), 32'h00FF);

    release_all();
    set_drv(0, 16'h00F0, 16'h0000);
    set_drv(2, 16'h00F0, 16'h0000);
    step();
    chk("agree contention", 32'(o_cont[0]), 32'h0);
    set_drv(2, 16'h00F1, 16'h0000);
    step();
    chk("conflict bus",   32'(o_bus[0]),   32'h00F1);
    chk("conflict flag",  32'(o_cont[0]),  32'h1);
    chk("conflict mask",  32'(o_fmask[0]), 32'h5);
    chk("conflict bits",  32'(o_fbits[0]), 32'h0001);
    chk("conflict count", 32'(o_cnt[0]),   32'd1);
    for (int i = 0; i < 11; i++) step();
    chk("sat count",   32'(o_cnt[3]),   32'd7);
    chk("wide count",  32'(o_cnt[0]),   32'd12);
    chk("sat mask",    32'(o_fmask[3]), 32'h5);
    chk("sat bits",    32'(o_fbits[3]), 32'h0001);

    release_all();
    clr = 1'b1;
    step();
    chk("clr count",  32'(o_cnt[3]),    32'd0);
    chk("clr sticky", 32'(o_sticky[3]), 32'h0);

    set_drv(0, 16'h0F00, 16'h0000);
    set_drv(1, 16'h0E00, 16'h0000);
    step();
    chk("clr+conf count",  32'(o_cnt[3]),    32'd1);
    chk("clr+conf sticky", 32'(o_sticky[3]), 32'h1);
    chk("clr+conf mask",   32'(o_fmask[3]),  32'h3);
    chk("clr+conf bits",   32'(o_fbits[3]),  32'h0100);

    clr = 1'b0;
    release_all();
    set_drv(0, 16'hFF0F, 16'h0000);
    set_drv(1, 16'h0FFF, 16'h0000);
    step();
    chk("wand bus",        32'(o_bus[4]),  32'h0F0F);
    chk("wand contention", 32'(o_cont[4]), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset bus",  32'(o_bus[4]),  32'hFFFF);
    chk("async reset cont", 32'(o_cont[4]), 32'h0);
    model_reset();
    step();
    reset = 1'b0;

    for (int i = 0; i < 500; i++) begin
      shared = W'($urandom);
      for (int k = 0; k < ND; k++) begin
        r = int'($urandom_range(0, 3));
        set_drv(k, ($urandom_range(0, 1) == 1) ? shared : W'($urandom),
                (r == 0) ? 16'hFFFF : ((r == 1) ? 16'h0000 : W'($urandom)));
      end
      clr   = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/md_bus_resolver.md
Name: md_bus_resolver

Overview:
- Parametrised, registered resolver for one shared board bus (VD/VA/ZD/ZA-class) with NDRV drivers.
- Each driver supplies per-bit value and per-bit release-enable (1 = released). The block produces the resolved bus one MCLK later.
- Undriven bits follow the selected idle mode: keeper, pull-up or pull-down.
- Adds a multi-driver contention monitor that a plain merge lacks: per-cycle flag, sticky flag, saturating counter and first-conflict capture, for debug and verification of bus ownership between m68k, z80, fc1004 and memories.

Parameters:
- WIDTH, 16, bus width in bits (1..32).
- NDRV, 4, number of drivers (2..8).
- IDLE_MODE, 0, undriven-bit value: 0 = keep previous resolved value, 1 = pull to 1, 2 = pull to 0.
- RESOLVE, 0, merge of multiple active drivers: 0 = OR, 1 = AND (wired-AND / open-drain).
- RESET_VAL, all ones, resolved bus value while reset is held and after reset.
- CNT_W, 8, contention counter width.

Ports:
- MCLK  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- drv_o  in  NDRV*WIDTH  driver values; driver k occupies bits [k*WIDTH +: WIDTH].
- drv_d  in  NDRV*WIDTH  per-bit release; 0 = driving, 1 = released. Same packing as drv_o.
- clr  in  1  synchronous clear of the sticky flag, counter and capture registers.
- bus  out  WIDTH  registered resolved bus.
- bus_driven  out  WIDTH  registered; bit = 1 if at least one driver drove that bit in the sampled cycle.
- contention  out  1  registered; 1 if the sampled cycle had a conflict.
- contention_sticky  out  1  set on any conflict; held until clr or reset.
- contention_count  out  CNT_W  number of conflicting cycles, saturating.
- first_mask  out  NDRV  drivers involved in the first conflict since clr/reset.
- first_bits  out  WIDTH  conflicting bit positions of that first conflict.

Behaviour:
- Reset (asynchronous): bus = RESET_VAL. All other outputs = 0. Reset mid-operation discards everything, including the keeper value.
- Latency: every output reflects the drv_o/drv_d/clr inputs sampled at the previous MCLK edge. There is no combinational path from input to output.
- Per bit b, active set A(b) = drivers k with drv_d[k][b] = 0.
  - A(b) non-empty: bus[b] <= OR (RESOLVE=0) or AND (RESOLVE=1) of drv_o[k][b] over A(b).
  - A(b) empty, IDLE_MODE=0: bus[b] holds its previous value.
  - A(b) empty, IDLE_MODE=1: bus[b] <= 1.
  - A(b) empty, IDLE_MODE=2: bus[b] <= 0.
  - bus_driven[b] <= (A(b) non-empty).
- Conflict on bit b: |A(b)| >= 2 and the drv_o values within A(b) are not all equal. Two or more drivers agreeing is not a conflict.
  - cycle_conflict = OR over b of the per-bit conflict.
  - conflict_bits = per-bit conflict vector.
  - conflict_mask[k] = 1 if driver k is in A(b) for any conflicting b.
- Register updates each cycle:
  - contention <= cycle_conflict.
  - Sticky, counter and capture follow the case rules below.
- Case clr=0, cycle_conflict=1:
  - sticky <= 1.
  - count <= count+1, saturating at 2^CNT_W-1 with no wrap.
  - If sticky was 0, first_mask <= conflict_mask and first_bits <= conflict_bits. Otherwise both hold.
- Case clr=1, cycle_conflict=0: sticky, count, first_mask and first_bits <= 0.
- Case clr=1, cycle_conflict=1 (simultaneous): clear and record in the same edge. sticky <= 1, count <= 1, first_* <= the current conflict. The contention output is unaffected by clr.
- Case clr=0, cycle_conflict=0: all hold.
- The keeper holds indefinitely. There is no decay to the idle value.
- Bits resolve independently. A partial-width drive (for example, a byte lane) keeps or pulls only the released bits.
- Parameter legality: a simulation-time error is raised if NDRV < 2, WIDTH < 1, CNT_W < 1 or IDLE_MODE > 2.

Test Plan:
- Reset/idle (WIDTH=16, NDRV=4, IDLE_MODE=0): assert reset with all drv_d = 1, then release. bus = 0xFFFF, bus_driven = 0, all flags 0 on every cycle.
- Keeper vs pull: driver 1 drives 0x1234 for one cycle, then releases.
  - IDLE_MODE=0: bus = 0x1234 on the next cycle and holds for 10 cycles.
  - IDLE_MODE=1: 0xFFFF one cycle after the release.
  - IDLE_MODE=2: 0x0000 one cycle after the release.
- Partial drive: driver 0 drives the low byte 0x5A (drv_d = 0xFF00) over a kept 0x1234. bus = 0x125A, bus_driven = 0x00FF.
- Agree vs conflict (RESOLVE=0): drivers 0 and 2 both drive 0x00F0. contention = 0.
  - Next cycle driver 2 drives 0x00F1 instead. bus = 0x00F1, contention = 1, first_mask = 4'b0101, first_bits = 0x0001, count = 1.
- Saturation/sticky (CNT_W=3): hold the conflict for 12 cycles. Count stops at 7, and first_* keep the first-conflict values.
  - clr alone: count = 0, sticky = 0.
  - clr together with a conflict: count = 1, sticky = 1, first_* = the new conflict.
- Wired-AND (RESOLVE=1, IDLE_MODE=1): drivers drive 0xFF0F and 0x0FFF. bus = 0x0F0F, contention = 1. Asynchronous reset asserted mid-conflict returns bus to RESET_VAL within the same cycle.
